// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the configurable convolution engine.
package conv_pkg;

   typedef enum logic [1:0] {LOAD_F, LOAD_X, COMPUTE, DRAIN} state_t;

   // Tap position flags travelling alongside the MAC pipeline.
   typedef struct packed {
      logic first;
      logic last;
   } tap_tag_t;

   localparam int SAT_W = 96;

   function automatic int acc_w(input int t, input int m);
      return 2 * t + $clog2(m);
   endfunction

   // Clamp to the signed t-bit range, then optionally drop negatives.
   function automatic logic signed [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] v,
                                                        input int t, input bit relu);
      logic signed [SAT_W-1:0] hi, lo, r;
      hi = (SAT_W'(1) << (t - 1)) - SAT_W'(1);
      lo = ~hi;
      r  = v;
      if (v > hi)      r = hi;
      else if (v < lo) r = lo;
      if (relu && r[SAT_W-1]) r = '0;
      return r;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// One convolution lane: registered product, accumulate with clear-on-first,
// saturated (and optionally rectified) result register.
module conv_mac
   import conv_pkg::*;
#(
   parameter int T    = 16,
   parameter int M    = 3,
   parameter bit RELU = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [T-1:0] x_op,
   input  logic signed [T-1:0] f_op,
   input  logic                acc_en,
   input  logic                acc_first,
   input  logic                acc_last,
   output logic signed [T-1:0] y
);
   localparam int AW = acc_w(T, M);

   logic signed [2*T-1:0]   prod;
   logic signed [AW-1:0]    acc, sum;
   logic signed [SAT_W-1:0] sat;

   // The last tap goes straight from product to the result register.
   always_comb begin
      sum = acc_first ? AW'(prod) : acc + AW'(prod);
      sat = sat_relu(SAT_W'(sum), T, RELU);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod <= '0;
         acc  <= '0;
         y    <= '0;
      end else begin
         prod <= x_op * f_op;
         if (acc_en) begin
            acc <= sum;
            if (acc_last) y <= T'(sat);
         end
      end
   end

endmodule

// File: rtl/conv_cfg_mac.sv
// Runtime-loadable 1-D convolution: P lanes compute N-M+1 saturated outputs
// per input vector and stream them through a valid/ready handshake.
module conv_cfg_mac
   import conv_pkg::*;
#(
   parameter int N    = 96,
   parameter int M    = 65,
   parameter int T    = 16,
   parameter int P    = 4,
   parameter bit RELU = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [T-1:0] f_data,
   input  logic         f_valid,
   output logic         f_ready,
   input  logic [T-1:0] x_data,
   input  logic         x_valid,
   output logic         x_ready,
   output logic [T-1:0] y_data,
   output logic         y_valid,
   input  logic         y_ready
);
   localparam int NOUT   = N - M + 1;
   localparam int XA     = (N > 1) ? $clog2(N) : 1;
   localparam int FA     = (M > 1) ? $clog2(M) : 1;
   localparam int TW     = $clog2(M + 1);
   localparam int DW     = (P > 1) ? $clog2(P) : 1;
   localparam int STAGES = 2;   // operand fetch, product

   if (M > N || (NOUT % P) != 0) begin : g_bad_cfg
      $error("conv_cfg_mac: requires M <= N and (N-M+1) divisible by P");
   end

   state_t              state, state_n;
   logic [FA-1:0]       f_cnt;
   logic [XA-1:0]       x_cnt, k0;
   logic [TW-1:0]       tap;
   logic [DW-1:0]       d_idx;
   logic [T-1:0]        f_mem [M];
   logic [T-1:0]        x_mem [N];
   logic [T-1:0]        f_op;
   logic [P-1:0][T-1:0] x_op, y_lane;
   logic [STAGES:1]     vld_pipe;
   tap_tag_t [STAGES:1] tag_pipe;
   tap_tag_t            tag_in;
   logic                f_fire, x_fire, y_fire, issue, last_lane, more_groups;

   assign f_ready     = (state == LOAD_F);
   assign x_ready     = (state == LOAD_X);
   assign y_valid     = (state == DRAIN);
   assign y_data      = y_lane[d_idx];
   assign f_fire      = f_valid && f_ready;
   assign x_fire      = x_valid && x_ready;
   assign y_fire      = y_valid && y_ready;
   assign issue       = (state == COMPUTE) && (tap < TW'(M));
   assign tag_in      = '{first: (tap == '0), last: (tap == TW'(M - 1))};
   assign last_lane   = (d_idx == DW'(P - 1));
   assign more_groups = (int'(k0) + P) < NOUT;

   always_comb begin
      state_n = state;
      case (state)
         LOAD_F:  if (f_fire && f_cnt == FA'(M - 1)) state_n = LOAD_X;
         LOAD_X:  if (x_fire && x_cnt == XA'(N - 1)) state_n = COMPUTE;
         COMPUTE: if (vld_pipe[STAGES] && tag_pipe[STAGES].last) state_n = DRAIN;
         DRAIN:   if (y_fire && last_lane) state_n = more_groups ? COMPUTE : LOAD_X;
         default: state_n = LOAD_F;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LOAD_F;
         f_cnt    <= '0;
         x_cnt    <= '0;
         tap      <= '0;
         k0       <= '0;
         d_idx    <= '0;
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         state    <= state_n;
         vld_pipe <= {vld_pipe[STAGES-1:1], issue};
         tag_pipe <= {tag_pipe[STAGES-1:1], tag_in};
         if (f_fire) f_cnt <= (f_cnt == FA'(M - 1)) ? '0 : f_cnt + 1'b1;
         if (x_fire) x_cnt <= (x_cnt == XA'(N - 1)) ? '0 : x_cnt + 1'b1;
         tap <= (state == COMPUTE) ? tap + TW'(issue) : '0;
         if (y_fire) begin
            d_idx <= last_lane ? '0 : d_idx + 1'b1;
            if (last_lane) k0 <= more_groups ? k0 + XA'(P) : '0;
         end
      end
   end

   // Storage carries no reset: the FSM always refills it before use.
   always_ff @(posedge clk) begin
      if (f_fire) f_mem[f_cnt] <= f_data;
      if (x_fire) x_mem[x_cnt] <= x_data;
      if (issue) begin
         f_op <= f_mem[FA'(tap)];
         for (int l = 0; l < P; l++) x_op[l] <= x_mem[XA'(int'(k0) + l + int'(tap))];
      end
   end

   for (genvar l = 0; l < P; l++) begin : g_lane
      conv_mac #(.T(T), .M(M), .RELU(RELU)) u_mac (
         .clk       (clk),
         .reset     (reset),
         .x_op      (x_op[l]),
         .f_op      (f_op),
         .acc_en    (vld_pipe[STAGES]),
         .acc_first (tag_pipe[STAGES].first),
         .acc_last  (tag_pipe[STAGES].last),
         .y         (y_lane[l])
      );
   end

endmodule

// File: tb/tb_conv_cfg_mac.sv
// Bench for conv_cfg_mac: fixed vector table plus randomized runs against a
// direct convolution model, on a RELU=0 and a RELU=1 instance.
module tb_conv_cfg_mac;
   localparam int N = 8, M = 3, T = 16, P = 2, NOUT = N - M + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0][T-1:0] f_data = '0, x_data = '0;
   logic [1:0]        f_valid = '0, x_valid = '0, y_ready = '0;
   logic [1:0][T-1:0] y_data;
   logic [1:0]        f_ready, x_ready, y_valid;
   logic [T-1:0]      y_data0, y_data1;
   logic              f_rdy0, f_rdy1, x_rdy0, x_rdy1, y_vld0, y_vld1;

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   assign y_data  = {y_data1, y_data0};
   assign f_ready = {f_rdy1, f_rdy0};
   assign x_ready = {x_rdy1, x_rdy0};
   assign y_valid = {y_vld1, y_vld0};

   conv_cfg_mac #(.N(N), .M(M), .T(T), .P(P), .RELU(1'b0)) u_dut0 (
      .clk(clk), .reset(reset),
      .f_data(f_data[0]), .f_valid(f_valid[0]), .f_ready(f_rdy0),
      .x_data(x_data[0]), .x_valid(x_valid[0]), .x_ready(x_rdy0),
      .y_data(y_data0), .y_valid(y_vld0), .y_ready(y_ready[0]));

   conv_cfg_mac #(.N(N), .M(M), .T(T), .P(P), .RELU(1'b1)) u_dut1 (
      .clk(clk), .reset(reset),
      .f_data(f_data[1]), .f_valid(f_valid[1]), .f_ready(f_rdy1),
      .x_data(x_data[1]), .x_valid(x_valid[1]), .x_ready(x_rdy1),
      .y_data(y_data1), .y_valid(y_vld1), .y_ready(y_ready[1]));

   typedef struct {
      int                     sel;
      logic [M-1:0][T-1:0]    f;
      logic [N-1:0][T-1:0]    x;
      logic [NOUT-1:0][T-1:0] y;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NOUT-1:0][T-1:0] model(input logic [M-1:0][T-1:0] f,
                                                    input logic [N-1:0][T-1:0] x, input bit relu);
      logic [NOUT-1:0][T-1:0] y;
      longint s;
      for (int k = 0; k < NOUT; k++) begin
         s = 0;
         for (int m = 0; m < M; m++) s += longint'($signed(x[k+m])) * longint'($signed(f[m]));
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
         if (relu && s < 0) s = 0;
         y[k] = T'(s);
      end
      return y;
   endfunction

   task automatic do_reset();
      reset = 1'b1; f_valid = '0; x_valid = '0; y_ready = '0;
      @(posedge clk); @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         check("rst_f_ready", f_ready[s], 1);
         check("rst_x_ready", x_ready[s], 0);
         check("rst_y_valid", y_valid[s], 0);
      end
      reset = 1'b0;
   endtask

   task automatic load_f(input int sel, input logic [M-1:0][T-1:0] f, input bit rnd, input bit hold_x);
      int  i = 0, cyc = 0;
      bit  fire;
      while (i < M && cyc < 200) begin
         cyc++;
         f_valid[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         f_data[sel]  = f[i];
         if (hold_x) begin
            x_valid[sel] = 1'b1;
            x_data[sel]  = 16'hDEAD;
            check("x_ready_in_load_f", x_ready[sel], 0);
         end
         fire = f_valid[sel] && f_ready[sel];
         @(posedge clk); @(negedge clk);
         if (fire) i++;
      end
      f_valid[sel] = 1'b0;
      if (i < M) check("load_f_timeout", i, M);
      check("x_ready_after_f", x_ready[sel], 1);
   endtask

   task automatic run_vec(input int sel, input logic [N-1:0][T-1:0] x, input bit rnd, input bit hold_f,
                          output logic [NOUT-1:0][T-1:0] got, output int lat);
      int xi = 0, yi = 0, cyc = 0, e0 = -1, fy = -1;
      bit fx, fyr;
      got = '0;
      while (yi < NOUT && cyc < 2000) begin
         cyc++;
         x_valid[sel] = (xi < N) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         x_data[sel]  = (xi < N) ? x[xi] : '0;
         y_ready[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (hold_f) f_valid[sel] = 1'b1;
         check("f_ready_idle", f_ready[sel], 0);
         if (xi < N) check("y_valid_before_load", y_valid[sel], 0);
         if (y_valid[sel] && fy < 0) fy = cyc;
         fx  = x_valid[sel] && x_ready[sel];
         fyr = y_valid[sel] && y_ready[sel];
         if (fyr) got[yi] = y_data[sel];
         if (fx && xi == N - 1) e0 = cyc;
         @(posedge clk); @(negedge clk);
         if (fx) xi++;
         if (fyr) yi++;
      end
      x_valid[sel] = 1'b0; y_ready[sel] = 1'b0; f_valid[sel] = 1'b0;
      if (yi < NOUT) check("run_timeout", yi, NOUT);
      lat = fy - e0;
   endtask

   initial begin
      logic [M-1:0][T-1:0]    fv, f123;
      logic [N-1:0][T-1:0]    xv;
      logic [NOUT-1:0][T-1:0] got, ev;
      int                     lat, cyc, xi;
      bit                     fire;

      for (int m = 0; m < M; m++) f123[m] = T'(m + 1);
      for (int i = 0; i < 5; i++) tbl[i].sel = (i >= 3) ? 1 : 0;
      for (int i = 0; i < N; i++) begin
         tbl[0].x[i] = T'(i + 1);
         tbl[1].x[i] = 16'h7FFF;
         tbl[2].x[i] = 16'h8000;
         tbl[3].x[i] = T'(N - i);
         tbl[4].x[i] = T'(i + 1);
      end
      tbl[0].f = f123;
      for (int m = 0; m < M; m++) begin
         tbl[1].f[m] = 16'h7FFF;
         tbl[2].f[m] = 16'h7FFF;
      end
      tbl[3].f[0] = 16'h0001; tbl[3].f[1] = 16'hFFFF; tbl[3].f[2] = 16'h0000;
      tbl[4].f = tbl[3].f;
      for (int k = 0; k < NOUT; k++) begin
         tbl[0].y[k] = T'(14 + 6 * k);
         tbl[1].y[k] = 16'h7FFF;
         tbl[2].y[k] = 16'h8000;
         tbl[3].y[k] = 16'h0001;
         tbl[4].y[k] = 16'h0000;
      end

      @(negedge clk);

      // Directed table; y_valid must rise M+2 edges after the COMPUTE entry
      // edge, which this sampling loop sees one iteration later.
      for (int i = 0; i < 5; i++) begin
         do_reset();
         load_f(tbl[i].sel, tbl[i].f, 1'b0, 1'b0);
         run_vec(tbl[i].sel, tbl[i].x, 1'b0, 1'b0, got, lat);
         for (int k = 0; k < NOUT; k++) check($sformatf("tbl%0d_y%0d", i, k), got[k], tbl[i].y[k]);
         if (i == 0) check("first_y_latency", lat, M + 3);
      end

      // Filter retention over random vectors with random handshakes.
      do_reset();
      load_f(0, f123, 1'b1, 1'b0);
      for (int v = 0; v < 20; v++) begin
         for (int i = 0; i < N; i++)
            xv[i] = $urandom_range(0, 1) ? T'($urandom) : T'(int'($urandom_range(0, 200)) - 100);
         ev = model(f123, xv, 1'b0);
         run_vec(0, xv, 1'b1, (v % 5) == 0, got, lat);
         for (int k = 0; k < NOUT; k++) check($sformatf("rnd%0d_y%0d", v, k), got[k], ev[k]);
      end

      // Random filter through the RELU instance.
      do_reset();
      for (int m = 0; m < M; m++) fv[m] = T'(int'($urandom_range(0, 100)) - 50);
      load_f(1, fv, 1'b1, 1'b0);
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < N; i++) xv[i] = T'(int'($urandom_range(0, 2000)) - 1000);
         ev = model(fv, xv, 1'b1);
         run_vec(1, xv, 1'b1, 1'b0, got, lat);
         for (int k = 0; k < NOUT; k++) check($sformatf("relu%0d_y%0d", v, k), got[k], ev[k]);
      end

      // x_valid held high through LOAD_F must not consume a sample.
      do_reset();
      load_f(0, f123, 1'b0, 1'b1);
      run_vec(0, tbl[0].x, 1'b0, 1'b0, got, lat);
      for (int k = 0; k < NOUT; k++) check($sformatf("holdx_y%0d", k), got[k], tbl[0].y[k]);

      // Reset in the middle of DRAIN, then a clean reload.
      do_reset();
      load_f(0, f123, 1'b0, 1'b0);
      xi = 0; cyc = 0;
      while (xi < N && cyc < 200) begin
         cyc++;
         x_valid[0] = 1'b1;
         x_data[0]  = T'(xi + 1);
         fire = x_ready[0];
         @(posedge clk); @(negedge clk);
         if (fire) xi++;
      end
      x_valid[0] = 1'b0;
      cyc = 0;
      while (!y_valid[0] && cyc < 200) begin
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      check("drain_reached", y_valid[0], 1);
      check("drain_first_y", y_data[0], 14);
      y_ready[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      y_ready[0] = 1'b0;
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      check("midrst_y_valid", y_valid[0], 0);
      check("midrst_x_ready", x_ready[0], 0);
      check("midrst_f_ready", f_ready[0], 1);
      reset = 1'b0;
      fv[0] = 16'h0003; fv[1] = 16'h0001; fv[2] = 16'h0002;
      load_f(0, fv, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) xv[i] = T'(int'($urandom_range(0, 600)) - 300);
      ev = model(fv, xv, 1'b0);
      run_vec(0, xv, 1'b0, 1'b0, got, lat);
      for (int k = 0; k < NOUT; k++) check($sformatf("reload_y%0d", k), got[k], ev[k]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_cfg_mac.md
# conv_cfg_mac

Parametrised 1-D signed fixed-point convolution engine with a runtime-loadable filter, saturating output and optional ReLU. It computes y[k] = Σ x[k+m]·f[m] over one input vector and streams the N−M+1 results through valid/ready handshakes. It generalises the fixed-size, fixed-filter conv_N_M_T_P engines by making width, length and parallelism parameters. It slots into the same streaming datapath position.

## Interface
- N, 96: input vector length.
- M, 65: filter taps; M ≤ N.
- T, 16: data and coefficient width, signed two's complement.
- P, 4: parallel MAC lanes; (N−M+1) % P == 0, checked at elaboration.
- RELU, 0: 1 clamps negative results to 0 after saturation.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- f_data  in  T  filter coefficient, f[0] first.
- f_valid  in  1  coefficient valid.
- f_ready  out  1  coefficient accepted when f_valid&&f_ready.
- x_data  in  T  input sample, x[0] first.
- x_valid  in  1  sample valid.
- x_ready  out  1  sample accepted when x_valid&&x_ready.
- y_data  out  T  result, y[0] first.
- y_valid  out  1  result valid.
- y_ready  in  1  result consumed when y_valid&&y_ready.

## Operation
- States: LOAD_F → LOAD_X → COMPUTE → DRAIN → (COMPUTE | LOAD_X).
- LOAD_F: f_ready=1. Accept M coefficients into filter memory, then go to LOAD_X. The filter is retained across all later vectors and is reloaded only after reset.
- LOAD_X: x_ready=1. Accept N samples, then go to COMPUTE. Input is not accepted in any other state.
- COMPUTE: P lanes compute outputs k0..k0+P−1 in parallel over M tap cycles. Then go to DRAIN.
- DRAIN: present the P results in ascending k, one per handshake.
  - After the last lane drains: if outputs remain, k0 += P and go to COMPUTE.
  - Otherwise go to LOAD_X.
- Arithmetic:
  - Full-precision products of 2T bits.
  - Accumulator of 2T+$clog2(M) bits, so no intermediate overflow.
  - Result saturates to [−2^(T−1), 2^(T−1)−1], then ReLU is applied if RELU=1.
- x_valid/f_valid asserted outside their load state have no effect. y_data is don't-care while y_valid=0.
- Reset at any point discards the filter, samples, partial sums and results, and returns to LOAD_F.

## Timing
- Reset values: f_ready=1 (in LOAD_F), x_ready=0, y_valid=0. All counters are 0.
- Ready signals are registered state decodes and never depend combinationally on the valid inputs.
- The state leaves LOAD_F on the edge accepting f[M−1]. x_ready=1 from the next cycle.
- First y_valid of each group: exactly M+2 cycles after the edge that enters COMPUTE.
  - 1 cycle memory read.
  - M MAC cycles, with the product register stage.
  - 1 cycle saturate/ReLU register.
- y_valid stays high and y_data stays stable until the handshake completes. With y_ready held high, one result per cycle.
- Peak throughput, for planning: (N−M+1)/P groups × (M+2+P) cycles per vector, plus N load cycles.

## Structure
- Package conv_pkg:
  - state enum.
  - accumulator-width function acc_w(T,M).
  - saturate/ReLU function sat_relu.
- Sub-module conv_mac: one lane.
  - Registered signed multiply, accumulate, clear-on-start.
  - Saturate/ReLU output register.
  - Instantiated P times via generate.
- Top level holds the FSM, the filter memory (M×T), the sample memory (N×T), the address counters and the drain mux.

## Test plan
Configuration for all cases unless stated: N=8, M=3, T=16, P=2.
- Filter [1,2,3], x=1..8 → y = 14,20,26,32,38,44. First y_valid exactly 5 cycles after the COMPUTE entry edge, with y_ready held high.
- Saturation, RELU=0:
  - f=0x7FFF×3, x=0x7FFF×8 → all y = 0x7FFF.
  - f=0x7FFF×3, x=0x8000×8 → all y = 0x8000.
- RELU=1, filter [1,−1,0]:
  - x=8..1 → all y = 1.
  - x=1..8 → all y = 0.
- Filter retention: load [1,2,3] once, then send 20 random vectors with x_valid/y_ready randomised at 50% → every result matches the reference model. f_ready stays 0 throughout.
- x_valid held high during LOAD_F → x_ready=0 and no sample is consumed until f[2] is accepted. f_valid held high during LOAD_X → f_ready stays 0.
- Reset asserted mid-DRAIN → on the next cycle y_valid=0, x_ready=0, f_ready=1. Reload the filter and a vector → correct outputs, with no stale results emitted.
